// File: rtl/sram_arbiter.sv
// Two-port (instruction / data) arbiter in front of a single SRAM controller.
// Optional build macro SRAM_ARB_RR_EN selects round-robin instead of D-over-I priority.
module sram_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              err,
  output logic              busy,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state;
  logic              owner_d;
  logic              last_grant_d;
  logic              we;
  logic              grant_d;
  logic              grant_we;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign cnt_next    = cnt + 1'b1;
  assign grant_we    = grant_d & d_we;

  always_comb begin
`ifdef SRAM_ARB_RR_EN
    if (d_req && i_req)
      grant_d = ~last_grant_d;
    else
      grant_d = d_req;
`else
    // last_grant is tracked in both builds; fixed priority never consults it
    grant_d = d_req | (1'b0 & last_grant_d);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      owner_d      <= 1'b1;
      last_grant_d <= 1'b1;
      we           <= 1'b0;
      cnt          <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      i_ack        <= 1'b0;
      d_ack        <= 1'b0;
      err          <= 1'b0;
      busy         <= 1'b0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
    end else begin
      i_ack        <= 1'b0;
      d_ack        <= 1'b0;
      err          <= 1'b0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            owner_d      <= grant_d;
            addr_q       <= grant_d ? d_addr : i_addr;
            wdata_q      <= grant_d ? d_wdata : '0;
            we           <= grant_we;
            mem_read_en  <= ~grant_we;
            mem_write_en <= grant_we;
            busy         <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (mem_ready) begin
            if (!we) begin
              if (owner_d) d_rdata <= mem_rdata;
              else         i_rdata <= mem_rdata;
            end
            d_ack <= owner_d;
            i_ack <= ~owner_d;
            state <= RESP;
          end else if (cnt_next == CNT_W'(TIMEOUT)) begin
            // ack and err are registered together so they land in the same RESP cycle
            d_ack <= owner_d;
            i_ack <= ~owner_d;
            err   <= 1'b1;
            state <= RESP;
          end else begin
            cnt <= cnt_next;
          end
        end
        RESP: begin
          last_grant_d <= owner_d;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: transaction-level model, memory-backed controller
// responder, and directed scenarios with literal expectations.
module tb_sram_arbiter;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [31:0] i_rdata, d_rdata, mem_address, mem_wdata, mem_rdata;
  logic        i_ack, d_ack, err, busy, mem_read_en, mem_write_en, mem_ready;

  sram_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .err(err), .busy(busy),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endfunction

  // Controller responder: memory array, ready after `lat` WAIT cycles (0 = never).
  bit [31:0] mem [bit [31:0]];
  int        lat = 1;
  int        wcnt = 0;

  function automatic bit [31:0] rd(bit [31:0] a);
    return mem.exists(a) ? mem[a] : 32'hA5A5A5A5;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      wcnt = 0;
      mem_ready = 1'b0;
    end else if (mem_read_en || mem_write_en) begin
      wcnt = 1;
      mem_ready = 1'b0;
      if (mem_write_en) mem[mem_address] = mem_wdata;
      mem_rdata = rd(mem_address);
    end else if (wcnt > 0) begin
      mem_ready = (lat != 0 && wcnt == lat);
      wcnt++;
    end
  end

  // Transaction model: k counts cycles since grant (1 = enable cycle, 2.. = waiting),
  // k = -1 marks the completion cycle, 0 = free.
  int        k = 0;
  bit        m_own_d, m_last_d, m_we;
  bit [31:0] m_addr, m_wdata, m_irdata, m_drdata;
  bit        m_iack, m_dack, m_err;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      k = 0; m_own_d = 1; m_last_d = 1; m_we = 0;
      m_addr = 0; m_wdata = 0; m_irdata = 0; m_drdata = 0;
      m_iack = 0; m_dack = 0; m_err = 0;
    end else begin
      m_iack = 0; m_dack = 0; m_err = 0;
      if (k == 0) begin
        if (i_req || d_req) begin
`ifdef SRAM_ARB_RR_EN
          m_own_d = (i_req && d_req) ? !m_last_d : d_req;
`else
          m_own_d = d_req;
`endif
          m_addr  = m_own_d ? d_addr : i_addr;
          m_wdata = m_own_d ? d_wdata : 0;
          m_we    = m_own_d && d_we;
          k = 1;
        end
      end else if (k == -1) begin
        m_last_d = m_own_d;
        k = 0;
      end else if (k >= 2 && (mem_ready || k - 1 == TO)) begin
        if (mem_ready && !m_we) begin
          if (m_own_d) m_drdata = mem_rdata;
          else         m_irdata = mem_rdata;
        end
        m_err  = !mem_ready;
        m_dack = m_own_d;
        m_iack = !m_own_d;
        k = -1;
      end else begin
        k++;
      end
    end
  end

  bit [31:0] addr_log[$];

  initial begin
    forever begin
      @(posedge clk);
      #2;
      chk("busy", busy, (k != 0));
      chk("rd_en", mem_read_en, (k == 1 && !m_we));
      chk("wr_en", mem_write_en, (k == 1 && m_we));
      chk("addr", mem_address, m_addr);
      if (m_own_d) chk("wdata", mem_wdata, m_wdata);
      chk("i_ack", i_ack, m_iack);
      chk("d_ack", d_ack, m_dack);
      chk("err", err, m_err);
      chk("i_rdata", i_rdata, m_irdata);
      chk("d_rdata", d_rdata, m_drdata);
      if (mem_read_en || mem_write_en) addr_log.push_back(mem_address);
    end
  end

  task automatic wait_ack(output int n, output bit was_d, output bit was_err);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(i_ack || d_ack) && n < 60);
    if (!(i_ack || d_ack)) chk("ack_timeout", 32'd0, 32'd1);
    was_d = d_ack;
    was_err = err;
  endtask

  int n;
  bit wd, we_err;
  bit seq [4];

  initial begin
    rst = 0; i_req = 0; d_req = 0; d_we = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
    mem[32'h400] = 32'hDEADBEEF;
    mem[32'h0]   = 32'h11110000;
    mem[32'h408] = 32'h22220408;
    mem[32'h600] = 32'h66006600;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_drdata", d_rdata, 0);
    rst = 1;
    @(negedge clk);

    // D read, ready in 3rd WAIT cycle
    lat = 3; addr_log.delete();
    d_req = 1; d_we = 0; d_addr = 32'h400;
    wait_ack(n, wd, we_err);
    d_req = 0;
    chk("t1_cycles", n, 5);
    chk("t1_is_d", wd, 1);
    chk("t1_err", we_err, 0);
    chk("t1_rdata", d_rdata, 32'hDEADBEEF);
    chk("t1_pulses", addr_log.size(), 1);
    chk("t1_addr", addr_log[0], 32'h400);
    @(negedge clk);

    // D write
    lat = 2;
    d_req = 1; d_we = 1; d_addr = 32'h404; d_wdata = 32'h12345678;
    wait_ack(n, wd, we_err);
    chk("t2_cycles", n, 4);
    chk("t2_wdata_held", mem_wdata, 32'h12345678);
    d_req = 0; d_we = 0;
    chk("t2_mem", mem[32'h404], 32'h12345678);
    chk("t2_rdata_kept", d_rdata, 32'hDEADBEEF);
    @(negedge clk);

    // Simultaneous I and D reads (last grant is D here)
    lat = 1; addr_log.delete();
    i_req = 1; i_addr = 32'h0; d_req = 1; d_addr = 32'h408;
    wait_ack(n, wd, we_err);
    if (wd) d_req = 0; else i_req = 0;
`ifdef SRAM_ARB_RR_EN
    chk("t3_first_d", wd, 0);
`else
    chk("t3_first_d", wd, 1);
`endif
    wait_ack(n, wd, we_err);
    i_req = 0; d_req = 0;
`ifdef SRAM_ARB_RR_EN
    chk("t3_second_d", wd, 1);
    chk("t3_addr0", addr_log[0], 32'h0);
    chk("t3_addr1", addr_log[1], 32'h408);
`else
    chk("t3_second_d", wd, 0);
    chk("t3_addr0", addr_log[0], 32'h408);
    chk("t3_addr1", addr_log[1], 32'h0);
`endif
    chk("t3_irdata", i_rdata, 32'h11110000);
    chk("t3_drdata", d_rdata, 32'h22220408);
    @(negedge clk);

    // Continuous dual requests
    i_req = 1; d_req = 1;
    for (int j = 0; j < 4; j++) begin
      wait_ack(n, wd, we_err);
      seq[j] = wd;
    end
    i_req = 0; d_req = 0;
`ifdef SRAM_ARB_RR_EN
    chk("t4_seq", {28'd0, seq[0], seq[1], seq[2], seq[3]}, 32'b0101);
`else
    chk("t4_seq", {28'd0, seq[0], seq[1], seq[2], seq[3]}, 32'b1111);
`endif
    @(negedge clk);

    // Timeout: controller never ready
    lat = 0;
    d_req = 1; d_addr = 32'h400;
    wait_ack(n, wd, we_err);
    d_req = 0;
    chk("t5_cycles", n, 17);
    chk("t5_err", we_err, 1);
    chk("t5_is_d", wd, 1);
    chk("t5_iack", i_ack, 0);
    chk("t5_rdata_kept", d_rdata, 32'h22220408);
    @(negedge clk);
    chk("t5_idle", busy, 0);
    @(negedge clk);

    // Reset during WAIT
    lat = 0;
    d_req = 1; d_addr = 32'h500;
    repeat (3) @(negedge clk);
    chk("t6_in_wait", busy, 1);
    rst = 0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_addr", mem_address, 0);
    chk("t6_drdata", d_rdata, 0);
    chk("t6_ack", d_ack, 0);
    d_addr = 32'h600; lat = 1;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("t6_reissue", mem_read_en, 1);
    chk("t6_readdr", mem_address, 32'h600);
    wait_ack(n, wd, we_err);
    d_req = 0;
    chk("t6_cycles", n, 2);
    chk("t6_rdata", d_rdata, 32'h66006600);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-requester arbiter that shares the single SRAM controller between the instruction-fetch port (I) and the MEM-stage data port (D).
- Sits between the pipeline memory ports and the SRAM controller's write_en/read_en/address/writeData/readData/ready handshake.
- Latches each granted transaction and issues it to the controller as a one-cycle enable pulse. It waits for ready, returns read data with a one-cycle ack, and guards the transfer with a timeout watchdog.

Parameters:
- ADDR_W, 32, address width of both ports and the controller address.
- DATA_W, 32, data width.
- TIMEOUT, 15, maximum WAIT cycles without mem_ready before the transaction is forcibly completed with error.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- i_req  in  1  instruction read request, level, held until i_ack
- i_addr  in  ADDR_W  instruction address
- i_rdata  out  DATA_W  registered instruction read data
- i_ack  out  1  one-cycle completion pulse for I
- d_req  in  1  data request, level, held until d_ack
- d_we  in  1  1=write, 0=read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  registered data read data
- d_ack  out  1  one-cycle completion pulse for D
- err  out  1  one-cycle pulse together with the ack of a timed-out transaction
- busy  out  1  high in every state except IDLE
- mem_read_en  out  1  controller read enable
- mem_write_en  out  1  controller write enable
- mem_address  out  ADDR_W  controller address
- mem_wdata  out  DATA_W  controller write data
- mem_rdata  in  DATA_W  controller read data
- mem_ready  in  1  controller ready

Behaviour:
- Reset values (rst=0, asynchronous): state=IDLE; all outputs 0; latched addr/wdata/we=0; owner=D; last_grant=D; timeout counter=0. Reset mid-transaction aborts it with no ack. The enables drop immediately.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, arbitrate, then latch owner, address, wdata and we (we forced 0 for I). Go to ISSUE.
  - Otherwise stay in IDLE.
- Arbitration (default): fixed priority, D over I. This prevents MEM-stage deadlock behind fetch.
- ISSUE:
  - Exactly one cycle. Assert mem_read_en (we=0) or mem_write_en (we=1).
  - Clear the timeout counter, then go to WAIT.
- WAIT:
  - Enables are 0. mem_address/mem_wdata stay driven from the latches; they are held stable from ISSUE through RESP.
  - mem_ready sampled 1: capture mem_rdata into the owner's rdata register (reads only), then go to RESP.
  - Otherwise increment the counter. When counter==TIMEOUT, set err_pending and go to RESP; the rdata register is left unchanged.
- RESP:
  - Pulse the owner's ack for one cycle. Pulse err if err_pending, then clear err_pending.
  - Update last_grant=owner and return to IDLE.
- Latency:
  - The ack occurs 1 cycle after the WAIT cycle that samples mem_ready.
  - Minimum request-to-ack time is 4 cycles (IDLE, ISSUE, WAIT, RESP) when mem_ready is already high in the first WAIT cycle.
- Request handling:
  - Requests are sampled only in IDLE. A req arriving in any other state waits.
  - A requester dropping req before its ack does not abort the transaction; the ack is still issued.
  - A new request is not accepted in the RESP cycle; the earliest re-grant is the IDLE cycle after RESP.
  - i_ack and d_ack are never high simultaneously.
- rdata registers hold their value until the next read completion on the same port. Writes leave d_rdata unchanged.
- Simultaneous requests: D wins. I is served on the next IDLE unless D re-requests; without RR, continuous D requests may starve I, which is accepted behaviour.

Optional Feature:
- Macro: SRAM_ARB_RR_EN.
- Defined: round-robin arbitration. With both reqs high in IDLE, grant the port opposite last_grant; a single req is granted directly.
- Undefined: fixed D-over-I priority; last_grant is still maintained but unused.

Test Plan:
- D read only:
  - Stimulus: d_req=1, d_we=0, d_addr=0x400. The controller model gives mem_ready in the 3rd WAIT cycle with mem_rdata=0xDEADBEEF.
  - Response: exactly one mem_read_en pulse with mem_address=0x400; d_ack 1 cycle later with d_rdata=0xDEADBEEF; err=0.
- D write only:
  - Stimulus: d_we=1, d_addr=0x404, d_wdata=0x12345678.
  - Response: one mem_write_en pulse; mem_wdata=0x12345678 held until d_ack; d_rdata unchanged.
- Simultaneous I+D reads, I at 0x0 and D at 0x408, with default build:
  - Response: D is acked first and I second. The mem_address sequence is 0x408 then 0x0, with no overlapping enables.
- Same simultaneous case with SRAM_ARB_RR_EN and last_grant=D:
  - Response: I is served first; under continuous dual requests the grants alternate I, D, I, D.
- Timeout: mem_ready held 0 forever.
  - Response: after ISSUE plus 15 WAIT cycles, the owner's ack and err pulse together; the FSM returns to IDLE; rdata is unchanged.
- Reset mid-WAIT: rst=0 during WAIT.
  - Response: all outputs go to 0 immediately, and no ack is issued.
  - After release with d_req=1, a fresh ISSUE occurs with the current d_addr.
